mult_div_unit: RTL and testbench

Iterative multiply/divide unit replacing the single-cycle combinational multiplier ahead of the HI/LO registers. It takes operands from register-file read ports 1 and 2 and executes MULT/MULTU/DIV/DIVU over 32 iteration cycles. It owns the HI and LO registers and drives them to the MFHI/MFLO write-back mux. Its busy output is the stall request to the PC/control path.

---
 rtl/mult_div_unit.sv | 178 +++++++++++++++++
 tb/tb_mult_div_unit.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Iterative 32-cycle multiply/divide unit owning the HI/LO registers.
// Signed operations run on magnitudes and apply sign correction in a final FIX cycle.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  localparam logic [5:0]         LAST_ITER = 6'(WIDTH - 1);
  localparam logic [WIDTH-1:0]   ONE_W     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE_2W    = {{(2*WIDTH-1){1'b0}}, 1'b1};

  function automatic logic [WIDTH-1:0] cneg_w(input logic [WIDTH-1:0] v, input logic en);
    return en ? (~v + ONE_W) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cneg_2w(input logic [2*WIDTH-1:0] v, input logic en);
    return en ? (~v + ONE_2W) : v;
  endfunction

  state_t             state_r;
  logic [5:0]         cnt_r;
  // Upper half: product high / partial remainder; lower half: multiplier / quotient bits.
  logic [2*WIDTH-1:0] acc_r;
  logic [WIDTH-1:0]   opb_r;
  logic [WIDTH-1:0]   a_raw_r;
  logic               is_div_r;
  logic               q_neg_r;
  logic               r_neg_r;
  logic               dz_r;

  logic               a_neg_s;
  logic               b_neg_s;
  logic [WIDTH-1:0]   abs_a_s;
  logic [WIDTH-1:0]   abs_b_s;
  logic [WIDTH:0]     mul_sum_s;
  logic [WIDTH:0]     div_shift_s;
  logic [WIDTH:0]     div_trial_s;
  logic [2*WIDTH-1:0] acc_step_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   fix_hi_s;
  logic [WIDTH-1:0]   fix_lo_s;

  // Operand magnitudes and sign capture for the launch cycle.
  always_comb begin
    a_neg_s = ~op[0] & a[WIDTH-1];
    b_neg_s = ~op[0] & b[WIDTH-1];
    abs_a_s = cneg_w(a, a_neg_s);
    abs_b_s = cneg_w(b, b_neg_s);
  end

  // One shift-add or restoring-divide step per RUN cycle.
  always_comb begin
    mul_sum_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, opb_r};
    div_shift_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
    div_trial_s = div_shift_s - {1'b0, opb_r};
    acc_step_s  = acc_r;
    if (is_div_r) begin
      if (div_trial_s[WIDTH] == 1'b0) begin
        acc_step_s = {div_trial_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
      end else begin
        acc_step_s = {div_shift_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
      end
    end else begin
      if (acc_r[0]) begin
        acc_step_s = {mul_sum_s, acc_r[WIDTH-1:1]};
      end else begin
        acc_step_s = {1'b0, acc_r[2*WIDTH-1:1]};
      end
    end
  end

  // Sign-corrected result; divide by zero bypasses correction and returns the raw dividend.
  always_comb begin
    prod_s   = cneg_2w(acc_r, q_neg_r);
    fix_hi_s = prod_s[2*WIDTH-1:WIDTH];
    fix_lo_s = prod_s[WIDTH-1:0];
    if (dz_r) begin
      fix_hi_s = a_raw_r;
      fix_lo_s = {WIDTH{1'b1}};
    end else if (is_div_r) begin
      fix_hi_s = cneg_w(acc_r[2*WIDTH-1:WIDTH], r_neg_r);
      fix_lo_s = cneg_w(acc_r[WIDTH-1:0], q_neg_r);
    end else begin
      fix_hi_s = prod_s[2*WIDTH-1:WIDTH];
      fix_lo_s = prod_s[WIDTH-1:0];
    end
  end

  // Control FSM with registered datapath and outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= IDLE;
      cnt_r    <= 6'd0;
      acc_r    <= {(2*WIDTH){1'b0}};
      opb_r    <= {WIDTH{1'b0}};
      a_raw_r  <= {WIDTH{1'b0}};
      is_div_r <= 1'b0;
      q_neg_r  <= 1'b0;
      r_neg_r  <= 1'b0;
      dz_r     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= {WIDTH{1'b0}};
      lo       <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state_r  <= RUN;
            cnt_r    <= 6'd0;
            acc_r    <= {{WIDTH{1'b0}}, abs_a_s};
            opb_r    <= abs_b_s;
            a_raw_r  <= a;
            is_div_r <= op[1];
            q_neg_r  <= a_neg_s ^ b_neg_s;
            r_neg_r  <= a_neg_s;
            dz_r     <= op[1] & (b == {WIDTH{1'b0}});
            busy     <= 1'b1;
            div_zero <= 1'b0;
          end else begin
            if (hi_we) begin
              hi <= wdata;
            end
            if (lo_we) begin
              lo <= wdata;
            end
          end
        end
        RUN: begin
          done  <= 1'b0;
          acc_r <= acc_step_s;
          cnt_r <= cnt_r + 6'd1;
          if (cnt_r == LAST_ITER) begin
            state_r <= FIX;
          end
        end
        FIX: begin
          hi       <= fix_hi_s;
          lo       <= fix_lo_s;
          done     <= 1'b1;
          busy     <= 1'b0;
          div_zero <= dz_r;
          cnt_r    <= 6'd0;
          state_r  <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= 6'd0;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vector table, corner sequences,
// and random operations checked against an arithmetic reference model.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_hi = 32'h0;
  logic [31:0] m_lo = 32'h0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ehi;
    logic [31:0] elo;
    logic        edz;
    int          glitch;
    bit          we_start;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: {div_zero, hi, lo} from plain integer arithmetic.
  function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint      sx;
    longint      sy;
    longint      q;
    longint      r;
    logic [63:0] ux;
    logic [63:0] uy;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'h0, x};
    uy = {32'h0, y};
    case (o)
      2'b00: begin
        q = sx * sy;
        return {1'b0, q[63:0]};
      end
      2'b01: begin
        p = ux * uy;
        return {1'b0, p};
      end
      2'b10: begin
        if (y == 32'h0) return {1'b1, x, 32'hFFFF_FFFF};
        q = sx / sy;
        r = sx % sy;
        return {1'b0, r[31:0], q[31:0]};
      end
      default: begin
        if (y == 32'h0) return {1'b1, x, 32'hFFFF_FFFF};
        return {1'b0, x % y, x / y};
      end
    endcase
  endfunction

  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [64:0] exp,
                        input int glitch, input bit we_start);
    int lat;
    int busy_cnt;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    if (we_start) begin
      lo_we = 1'b1;
      wdata = 32'hA5A5_A5A5;
    end
    @(posedge clk); #1;
    start = 1'b0; lo_we = 1'b0;
    op = 2'($urandom); a = $urandom; b = $urandom;
    chk({name, "/busy_e0"}, 64'(busy), 64'd1);
    chk({name, "/done_e0"}, 64'(done), 64'd0);
    chk({name, "/hilo_hold_e0"}, {hi, lo}, {m_hi, m_lo});
    lat = 0;
    busy_cnt = 1;
    while (done !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (busy === 1'b1) busy_cnt++;
      if (glitch > 0 && lat == glitch - 1) begin
        start = 1'b1; op = 2'b01; a = 32'h1234_5678; b = 32'h0000_0003;
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
      end
      if (glitch > 0 && lat == glitch) begin
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        chk({name, "/hilo_busy_write"}, {hi, lo}, {m_hi, m_lo});
      end
    end
    chk({name, "/latency"}, 64'(lat), 64'd33);
    chk({name, "/busy_cycles"}, 64'(busy_cnt), 64'd33);
    chk({name, "/hi"}, 64'(hi), 64'(exp[63:32]));
    chk({name, "/lo"}, 64'(lo), 64'(exp[31:0]));
    chk({name, "/div_zero"}, 64'(div_zero), 64'(exp[64]));
    m_hi = exp[63:32];
    m_lo = exp[31:0];
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [1:0]  rop;

    tbl[0]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 0, 1'b0};
    tbl[1]  = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 0, 1'b0};
    tbl[2]  = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 0, 1'b0};
    tbl[3]  = '{2'b11, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1, 0, 1'b0};
    tbl[4]  = '{2'b01, 32'h0000_0002, 32'h0000_0003, 32'h0000_0000, 32'h0000_0006, 1'b0, 0, 1'b1};
    tbl[5]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 10, 1'b0};
    tbl[6]  = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1, 0, 1'b0};
    tbl[7]  = '{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 0, 1'b0};
    tbl[8]  = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 0, 1'b0};
    tbl[9]  = '{2'b11, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 0, 1'b0};
    tbl[10] = '{2'b11, 32'h0000_0005, 32'h0000_0007, 32'h0000_0005, 32'h0000_0000, 1'b0, 0, 1'b0};
    tbl[11] = '{2'b00, 32'h0001_0000, 32'hFFFF_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 0, 1'b0};

    rst = 1'b0; start = 1'b0; op = 2'b00; a = 32'h0; b = 32'h0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset/busy", 64'(busy), 64'd0);
    chk("reset/done", 64'(done), 64'd0);
    chk("reset/div_zero", 64'(div_zero), 64'd0);
    chk("reset/hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b,
             {tbl[i].edz, tbl[i].ehi, tbl[i].elo}, tbl[i].glitch, tbl[i].we_start);
    end

    // Direct HI/LO writes while idle.
    @(negedge clk);
    hi_we = 1'b1; wdata = 32'h1234_5678;
    @(posedge clk); #1;
    hi_we = 1'b0;
    chk("mthi/hi", 64'(hi), 64'h1234_5678);
    chk("mthi/lo", 64'(lo), 64'(m_lo));
    chk("mthi/done", 64'(done), 64'd0);
    m_hi = 32'h1234_5678;
    @(negedge clk);
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    hi_we = 1'b0; lo_we = 1'b0;
    chk("mthilo/hilo", {hi, lo}, 64'hCAFE_F00D_CAFE_F00D);
    m_hi = 32'hCAFE_F00D;
    m_lo = 32'hCAFE_F00D;

    // Asynchronous reset in the middle of RUN, then a clean restart.
    @(negedge clk);
    start = 1'b1; op = 2'b01; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("midreset/busy", 64'(busy), 64'd0);
    chk("midreset/done", 64'(done), 64'd0);
    chk("midreset/hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    m_hi = 32'h0;
    m_lo = 32'h0;
    run_op("after_reset", 2'b01, 32'd5, 32'd5, {1'b0, 32'h0, 32'h0000_0019}, 0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      rop = 2'($urandom);
      case ($urandom_range(0, 3))
        0: ra = 32'h8000_0000;
        1: ra = $urandom_range(0, 100);
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 4))
        0: rb = 32'h0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = $urandom_range(1, 50);
        default: rb = $urandom;
      endcase
      run_op($sformatf("rand%0d", i), rop, ra, rb, model(rop, ra, rb), 0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
